// File: rtl/gb_wr_ctrl.sv
// Write-side controller for the global-buffer bank ring: packs 2^PORT_SEP input
// beats per SRAM word, fills the current bank and hands full banks to the reader.
module gb_wr_ctrl #(
    parameter int SRAM_ADDRWIDTH = 9,
    parameter int DATA_WIDTH     = 8,
    parameter int PORT_SEP       = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [3:0]                          SRAM_num,
    input  logic [SRAM_ADDRWIDTH-1:0]           Word_num,
    input  logic                                IFSRAM_val,
    input  logic [DATA_WIDTH-1:0]               IFSRAM_data,
    output logic                                SRAMIF_rdy,
    output logic                                write_en,
    output logic [SRAM_ADDRWIDTH-1:0]           addr_Wr,
    output logic [(DATA_WIDTH<<PORT_SEP)-1:0]   wr_data,
    output logic [3:0]                          Wr_ID,
    output logic                                write_SRAM_done,
    input  logic                                read_SRAM_done,
    input  logic                                pull_back,
    output logic                                SRAM_prepare,
    output logic [3:0]                          next_Rd_ID
);

    localparam int BEATS  = 1 << PORT_SEP;
    localparam int WORD_W = DATA_WIDTH * BEATS;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'b00,
        WR_WRITE = 2'b01,
        WR_FLUSH = 2'b11
    } wr_state_t;

    wr_state_t                  r_state;
    wr_state_t                  w_state_next;

    logic [PORT_SEP-1:0]        r_cnt_t;
    logic [SRAM_ADDRWIDTH-1:0]  r_addr_cnt;
    logic [WORD_W-1:0]          r_pack;
    logic [WORD_W-1:0]          w_pack_next;
    logic [15:0]                r_full;
    logic [15:0]                w_full_next;
    logic [3:0]                 r_wr_id;
    logic [3:0]                 r_rd_id;
    logic                       r_write_en;
    logic                       r_write_done;
    logic [SRAM_ADDRWIDTH-1:0]  r_addr_wr;
    logic [WORD_W-1:0]          r_wr_data;

    logic [3:0]                 w_last_bank;
    logic [SRAM_ADDRWIDTH-1:0]  w_last_addr;
    logic                       w_accept;
    logic                       w_word_done;
    logic                       w_bank_done;
    logic                       w_rd_event;

    function automatic logic [3:0] ringNext(input logic [3:0] id, input logic [3:0] last);
        return (id == last) ? 4'd0 : id + 4'd1;
    endfunction

    // SRAM_num of 0 behaves as a one-bank ring; Word_num of 0 wraps to all-ones.
    assign w_last_bank = (SRAM_num == 4'd0) ? 4'd0 : SRAM_num - 4'd1;
    assign w_last_addr = Word_num - SRAM_ADDRWIDTH'(1);

    assign w_accept    = IFSRAM_val & (r_state == WR_WRITE);
    assign w_word_done = w_accept & (&r_cnt_t);
    assign w_bank_done = w_word_done & (r_addr_cnt == w_last_addr);
    assign w_rd_event  = read_SRAM_done | pull_back;

    assign SRAMIF_rdy      = (r_state == WR_WRITE);
    assign write_en        = r_write_en;
    assign addr_Wr         = r_addr_wr;
    assign wr_data         = r_wr_data;
    assign Wr_ID           = r_wr_id;
    assign write_SRAM_done = r_write_done;
    assign SRAM_prepare    = r_full[r_rd_id];
    assign next_Rd_ID      = r_rd_id;

    always_comb begin
        w_pack_next = r_pack;
        for (int k = 0; k < BEATS; k++) begin
            if (r_cnt_t == PORT_SEP'(k)) begin
                w_pack_next[k*DATA_WIDTH +: DATA_WIDTH] = IFSRAM_data;
            end
        end
    end

    // Reader clear and writer set never hit the same bank, so their order is irrelevant.
    always_comb begin
        w_full_next = r_full;
        if (w_rd_event) begin
            w_full_next[r_rd_id] = 1'b0;
        end
        if (r_write_done) begin
            w_full_next[r_wr_id] = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = WR_IDLE;
        end else begin
            case (r_state)
                WR_IDLE:  if (!r_full[r_wr_id]) w_state_next = WR_WRITE;
                WR_WRITE: if (w_bank_done)      w_state_next = WR_FLUSH;
                WR_FLUSH: w_state_next = WR_IDLE;
                default:  w_state_next = WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_t    <= '0;
            r_addr_cnt <= '0;
            r_pack     <= '0;
        end else if (start) begin
            r_cnt_t    <= '0;
            r_addr_cnt <= '0;
            r_pack     <= '0;
        end else begin
            if (w_accept) begin
                r_cnt_t <= r_cnt_t + PORT_SEP'(1);
                r_pack  <= w_pack_next;
            end
            if (w_word_done) begin
                r_addr_cnt <= (r_addr_cnt == w_last_addr) ? '0 : r_addr_cnt + SRAM_ADDRWIDTH'(1);
            end
        end
    end

    // A word completed in a start cycle is dropped along with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write_en   <= 1'b0;
            r_write_done <= 1'b0;
            r_addr_wr    <= '0;
            r_wr_data    <= '0;
        end else if (start) begin
            r_write_en   <= 1'b0;
            r_write_done <= 1'b0;
            r_addr_wr    <= '0;
            r_wr_data    <= '0;
        end else begin
            r_write_en   <= w_word_done;
            r_write_done <= w_bank_done;
            if (w_word_done) begin
                r_addr_wr <= r_addr_cnt;
                r_wr_data <= w_pack_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full  <= '0;
            r_wr_id <= '0;
            r_rd_id <= '0;
        end else if (start) begin
            r_full  <= '0;
            r_wr_id <= '0;
            r_rd_id <= '0;
        end else begin
            r_full <= w_full_next;
            if (r_write_done) begin
                r_wr_id <= ringNext(r_wr_id, w_last_bank);
            end
            if (w_rd_event) begin
                r_rd_id <= ringNext(r_rd_id, w_last_bank);
            end
        end
    end

endmodule

// File: tb/tb_gb_wr_ctrl.sv
// Bench for gb_wr_ctrl: directed scenarios plus a randomized run, all checked
// cycle by cycle against a transaction-level model of the bank ring.
module tb_gb_wr_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int PS    = 1;
    localparam int BEATS = 1 << PS;
    localparam int WW    = DW * BEATS;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [3:0]     SRAM_num;
    logic [AW-1:0]  Word_num;
    logic           IFSRAM_val;
    logic [DW-1:0]  IFSRAM_data;
    logic           SRAMIF_rdy;
    logic           write_en;
    logic [AW-1:0]  addr_Wr;
    logic [WW-1:0]  wr_data;
    logic [3:0]     Wr_ID;
    logic           write_SRAM_done;
    logic           read_SRAM_done;
    logic           pull_back;
    logic           SRAM_prepare;
    logic [3:0]     next_Rd_ID;

    always #5 clk = ~clk;

    gb_wr_ctrl #(
        .SRAM_ADDRWIDTH (AW),
        .DATA_WIDTH     (DW),
        .PORT_SEP       (PS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .SRAM_num        (SRAM_num),
        .Word_num        (Word_num),
        .IFSRAM_val      (IFSRAM_val),
        .IFSRAM_data     (IFSRAM_data),
        .SRAMIF_rdy      (SRAMIF_rdy),
        .write_en        (write_en),
        .addr_Wr         (addr_Wr),
        .wr_data         (wr_data),
        .Wr_ID           (Wr_ID),
        .write_SRAM_done (write_SRAM_done),
        .read_SRAM_done  (read_SRAM_done),
        .pull_back       (pull_back),
        .SRAM_prepare    (SRAM_prepare),
        .next_Rd_ID      (next_Rd_ID)
    );

    int checks   = 0;
    int failures = 0;

    // Model: expected outputs for the current cycle plus abstract ring bookkeeping.
    bit             m_rdy;
    bit             m_we;
    bit             m_done;
    logic [AW-1:0]  m_addr;
    logic [WW-1:0]  m_data;
    bit             m_full [16];
    int             m_wr;
    int             m_rd;
    int             m_cycle;
    int             m_openAt;
    int             m_wordIdx;
    logic [DW-1:0]  m_beats [$];

    logic [WW-1:0]  obsData [$];
    logic [AW-1:0]  obsAddr [$];
    logic [AW-1:0]  lastDoneAddr;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelClear();
        m_rdy     = 0;
        m_we      = 0;
        m_done    = 0;
        m_addr    = '0;
        m_data    = '0;
        foreach (m_full[i]) m_full[i] = 0;
        m_wr      = 0;
        m_rd      = 0;
        m_wordIdx = 0;
        m_beats.delete();
    endtask

    task automatic modelStep(input bit st, input bit val, input logic [DW-1:0] d,
                             input bit rdd, input bit pb);
        int            nb;
        int            wpb;
        bit            acc;
        bit            wordDone;
        bit            bankDone;
        bit            newRdy;
        logic [WW-1:0] word;
        nb       = (SRAM_num == 0) ? 1 : int'(SRAM_num);
        wpb      = (Word_num == 0) ? (1 << AW) : int'(Word_num);
        acc      = val && m_rdy;
        wordDone = 0;
        bankDone = 0;
        word     = '0;
        if (st) begin
            modelClear();
            m_openAt = m_cycle + 1;
        end else begin
            if (acc) begin
                m_beats.push_back(d);
                if (m_beats.size() == BEATS) begin
                    wordDone = 1;
                    for (int k = 0; k < BEATS; k++) word[k*DW +: DW] = m_beats[k];
                    bankDone = (m_wordIdx == wpb - 1);
                end
            end
            // Writer reopens on the third cycle after a bank's last beat, if its bank is free.
            if (m_rdy) newRdy = !bankDone;
            else       newRdy = (m_cycle >= m_openAt) && !m_full[m_wr];
            if (bankDone) m_openAt = m_cycle + 2;
            if (rdd || pb) begin
                m_full[m_rd] = 0;
                m_rd = (m_rd + 1) % nb;
            end
            if (m_done) begin
                m_full[m_wr] = 1;
                m_wr = (m_wr + 1) % nb;
            end
            m_we   = wordDone;
            m_done = bankDone;
            if (wordDone) begin
                m_addr    = AW'(m_wordIdx);
                m_data    = word;
                m_wordIdx = bankDone ? 0 : m_wordIdx + 1;
                m_beats.delete();
            end
            m_rdy = newRdy;
        end
        m_cycle++;
    endtask

    task automatic compareModel();
        checkOutput("rdy",        SRAMIF_rdy,      m_rdy);
        checkOutput("write_en",   write_en,        m_we);
        checkOutput("addr_Wr",    addr_Wr,         m_addr);
        checkOutput("wr_data",    wr_data,         m_data);
        checkOutput("wr_done",    write_SRAM_done, m_done);
        checkOutput("Wr_ID",      Wr_ID,           m_wr);
        checkOutput("next_Rd_ID", next_Rd_ID,      m_rd);
        checkOutput("prepare",    SRAM_prepare,    m_full[m_rd]);
    endtask

    // One cycle: entered and left at a falling edge.
    task automatic applyStimulus(input bit st, input bit val, input logic [DW-1:0] d,
                                 input bit rdd, input bit pb);
        if (write_en === 1'b1) begin
            obsData.push_back(wr_data);
            obsAddr.push_back(addr_Wr);
        end
        if (write_SRAM_done === 1'b1) lastDoneAddr = addr_Wr;
        compareModel();
        start          = st;
        IFSRAM_val     = val;
        IFSRAM_data    = d;
        read_SRAM_done = rdd;
        pull_back      = pb;
        modelStep(st, val, d, rdd, pb);
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0);
    endtask

    task automatic startWith(input logic [3:0] banks, input logic [AW-1:0] words);
        SRAM_num = banks;
        Word_num = words;
        applyStimulus(1, 0, '0, 0, 0);
        obsData.delete();
        obsAddr.delete();
        lastDoneAddr = '0;
    endtask

    task automatic streamBeats(input int n, input int first, input bit sparse);
        int sent = 0;
        int cyc  = 0;
        bit v;
        bit a;
        while (sent < n && cyc < 300) begin
            v = sparse ? (cyc % 2 == 0) : 1'b1;
            a = v && m_rdy;
            applyStimulus(0, v, DW'(first + sent), 0, 0);
            if (a) sent++;
            cyc++;
        end
        if (sent < n) checkOutput("stream_timeout", sent, n);
    endtask

    function automatic logic [31:0] qData(input int i);
        return (i < obsData.size()) ? 32'(obsData[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] qAddr(input int i);
        return (i < obsAddr.size()) ? 32'(obsAddr[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic checkFill(input string tag);
        checkOutput({tag, "_writes"}, obsData.size(), 3);
        for (int i = 0; i < 3; i++) begin
            checkOutput({tag, "_data"}, qData(i), ((2*i + 2) << 8) | (2*i + 1));
            checkOutput({tag, "_addr"}, qAddr(i), i);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        SRAM_num       = 4'd2;
        Word_num       = AW'(3);
        IFSRAM_val     = 1'b0;
        IFSRAM_data    = '0;
        read_SRAM_done = 1'b0;
        pull_back      = 1'b0;
        lastDoneAddr   = '0;
        m_cycle        = 0;
        modelClear();
        repeat (3) @(negedge clk);
        checkOutput("reset_rdy",      SRAMIF_rdy,   0);
        checkOutput("reset_write_en", write_en,     0);
        checkOutput("reset_wr_id",    Wr_ID,        0);
        rst_n    = 1'b1;
        m_openAt = m_cycle;

        // Basic fill, then ring full and release.
        startWith(4'd2, AW'(3));
        streamBeats(6, 1, 0);
        checkOutput("fill_done_pulse", write_SRAM_done, 1);
        checkOutput("fill_done_addr",  addr_Wr,         2);
        idleCycles(1);
        checkOutput("fill_prepare", SRAM_prepare, 1);
        checkOutput("fill_wr_id",   Wr_ID,        1);
        checkOutput("fill_rd_id",   next_Rd_ID,   0);
        idleCycles(1);
        checkFill("basic");
        streamBeats(6, 7, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 8'hAA, 0, 0);
            checkOutput("ringfull_rdy", SRAMIF_rdy, 0);
        end
        applyStimulus(0, 0, '0, 1, 0);
        checkOutput("release_rd_id",     next_Rd_ID,   1);
        checkOutput("release_prepare",   SRAM_prepare, 1);
        checkOutput("release_rdy_early", SRAMIF_rdy,   0);
        idleCycles(1);
        checkOutput("release_rdy",   SRAMIF_rdy, 1);
        checkOutput("release_wr_id", Wr_ID,      0);

        // Sparse valid.
        startWith(4'd2, AW'(3));
        streamBeats(6, 1, 1);
        idleCycles(3);
        checkFill("sparse");

        // Abort mid-word, with a word-completing beat in the start cycle.
        startWith(4'd2, AW'(3));
        streamBeats(3, 1, 0);
        applyStimulus(1, 1, 8'h04, 0, 0);
        checkOutput("abort_write_en", write_en,     0);
        checkOutput("abort_addr",     addr_Wr,      0);
        checkOutput("abort_wr_id",    Wr_ID,        0);
        checkOutput("abort_prepare",  SRAM_prepare, 0);
        idleCycles(2);
        checkOutput("abort_writes", obsData.size(), 1);
        obsData.delete();
        obsAddr.delete();
        streamBeats(6, 1, 0);
        idleCycles(2);
        checkFill("refill");

        // Address wrap with Word_num = 0.
        startWith(4'd2, AW'(0));
        streamBeats(34, 16, 0);
        idleCycles(2);
        for (int i = 0; i < 16; i++) checkOutput("wrap_addr", qAddr(i), i);
        checkOutput("wrap_done_addr", lastDoneAddr, 15);
        checkOutput("wrap_next_bank", qAddr(16), 0);

        // pull_back coincident with the last write of bank 1 while bank 0 is full.
        startWith(4'd2, AW'(1));
        streamBeats(4, 32, 0);
        checkOutput("simul_done_pulse", write_SRAM_done, 1);
        checkOutput("simul_wr_id_pre",  Wr_ID,           1);
        applyStimulus(0, 0, '0, 0, 1);
        checkOutput("simul_wr_id",   Wr_ID,        0);
        checkOutput("simul_rd_id",   next_Rd_ID,   1);
        checkOutput("simul_prepare", SRAM_prepare, 1);

        // Randomized traffic with an occasional restart and ring reconfiguration.
        startWith(4'd3, AW'(2));
        for (int c = 0; c < 1500; c++) begin
            bit st;
            bit rdd;
            bit pb;
            st  = ($urandom_range(0, 249) == 0);
            rdd = 0;
            pb  = 0;
            if (st) begin
                SRAM_num = 4'($urandom_range(0, 4));
                Word_num = AW'($urandom_range(0, 5));
            end
            if (m_full[m_rd] && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 4) == 0) pb = 1;
                else                           rdd = 1;
            end
            applyStimulus(st, $urandom_range(0, 9) < 7, DW'($urandom), rdd, pb);
        end

        // Asynchronous reset mid-word.
        startWith(4'd2, AW'(3));
        streamBeats(7, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rdy",      SRAMIF_rdy,      0);
        checkOutput("async_write_en", write_en,        0);
        checkOutput("async_addr",     addr_Wr,         0);
        checkOutput("async_data",     wr_data,         0);
        checkOutput("async_wr_id",    Wr_ID,           0);
        checkOutput("async_done",     write_SRAM_done, 0);
        checkOutput("async_prepare",  SRAM_prepare,    0);
        checkOutput("async_rd_id",    next_Rd_ID,      0);
        start          = 1'b0;
        IFSRAM_val     = 1'b0;
        read_SRAM_done = 1'b0;
        pull_back      = 1'b0;
        @(negedge clk);
        modelClear();
        rst_n    = 1'b1;
        m_openAt = m_cycle;
        streamBeats(6, 1, 0);
        idleCycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
